pc_fetch_unit: RTL and testbench

Program-counter and next-PC stage directly upstream of the single-cycle CPU's instruction memory; drives `ins_addr` into it every cycle. Selects the next PC from sequential, branch, jump or jump-register sources and supports stall and halt. Traps misaligned jump-register targets and counts fetched instructions for debug and performance readout.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/npc_calc.sv | 44 ++++
 rtl/pc_fetch_unit.sv | 89 ++++++++
 tb/tb_pc_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and enums for the fetch stage of the single-cycle CPU.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          JT_W         = 26;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    ERROR
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } npc_sel_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC select (jr > jump > branch > sequential) and jr misalign detect.
// Zero latency; no flow control, the parent decides whether next_pc is taken.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0]     pc,
  input  logic            branch_taken,
  input  logic [31:0]     branch_offset,
  input  logic            jump,
  input  logic [JT_W-1:0] jump_target,
  input  logic            jr,
  input  logic [31:0]     jr_addr,
  output logic [31:0]     pc_plus4,
  output logic [31:0]     next_pc,
  output logic            misalign
);

  npc_sel_e sel;

  assign pc_plus4 = pc + PC_INC;
  assign misalign = jr && (jr_addr[1:0] != 2'b00);

  always_comb begin
    sel = SEL_SEQ;
    if (jr)
      sel = SEL_JR;
    else if (jump)
      sel = SEL_J;
    else if (branch_taken)
      sel = SEL_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_JR:  next_pc = jr_addr;
      // Jump keeps the 256 MB region of the delay-slot address.
      SEL_J:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      SEL_BR:  next_pc = pc_plus4 + (branch_offset << 2);
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and saturating fetch counter feeding instruction memory.
// Controls take effect on ins_addr one cycle later; stall holds PC and counter.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  input  logic             halt_req,
  output logic [31:0]      ins_addr,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic [31:0]      next_pc;
  logic             misalign;

  npc_calc u_npc_calc (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misalign      (misalign)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_inc = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          // A misaligned jr freezes PC on the jr itself so debug can see it.
          if (misalign) begin
            state_d = ERROR;
          end else begin
            pc_d    = next_pc;
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ins_addr     = pc_q;
  assign fetch_valid  = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign misalign_err = (state_q == ERROR);
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural model pushes expected outputs per cycle.
module tb_pc_fetch_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          branch_taken;
  logic [31:0]   branch_offset;
  logic          jump;
  logic [25:0]   jump_target;
  logic          jr;
  logic [31:0]   jr_addr;
  logic          halt_req;
  logic [31:0]   ins_addr;
  logic [31:0]   pc_plus4;
  logic          fetch_valid;
  logic          halted;
  logic          misalign_err;
  logic [CW-1:0] fetch_count;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .halt_req      (halt_req),
    .ins_addr      (ins_addr),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  typedef struct packed {
    logic [31:0]   addr;
    logic [31:0]   p4;
    logic          vld;
    logic          hlt;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model state: 0 boot, 1 run, 2 halt, 3 error
  int            m_st = 0;
  logic [31:0]   m_pc = 32'h0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] seq;
    logic [31:0] nxt;
    seq = m_pc + 32'd4;
    nxt = seq;
    if (!rst_n) begin
      m_st = 0; m_pc = 32'h0; m_cnt = '0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (halt_req) m_st = 2;
      else if (!stall) begin
        if (jr && jr_addr[1:0] != 2'b00) m_st = 3;
        else begin
          if (jr) nxt = jr_addr;
          else if (jump) nxt = {seq[31:28], jump_target, 2'b00};
          else if (branch_taken) nxt = seq + {branch_offset[29:0], 2'b00};
          m_pc = nxt;
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit br, input logic [31:0] off,
                     input bit j, input logic [25:0] tg, input bit jrv,
                     input logic [31:0] ja, input bit h);
    exp_t e;
    rst_n = r; stall = st; branch_taken = br; branch_offset = off;
    jump = j; jump_target = tg; jr = jrv; jr_addr = ja; halt_req = h;
    model_step();
    e.addr = m_pc; e.p4 = m_pc + 32'd4; e.vld = (m_st == 1);
    e.hlt = (m_st == 2); e.err = (m_st == 3); e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("sb_addr", ins_addr, e.addr);
      chk("sb_p4", pc_plus4, e.p4);
      chk("sb_vld", {31'b0, fetch_valid}, {31'b0, e.vld});
      chk("sb_hlt", {31'b0, halted}, {31'b0, e.hlt});
      chk("sb_err", {31'b0, misalign_err}, {31'b0, e.err});
      chk("sb_cnt", {28'b0, fetch_count}, {28'b0, e.cnt});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  task automatic do_jr(input logic [31:0] a);
    cyc(1, 0, 0, 32'h0, 0, 26'h0, 1, a, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0; jr = 1'b0; jr_addr = '0; halt_req = 1'b0;
    @(negedge clk);

    // Reset and the BOOT bubble
    do_reset(2);
    chk("boot_addr", ins_addr, 32'h0);
    chk("boot_vld", {31'b0, fetch_valid}, 32'h0);
    chk("boot_cnt", {28'b0, fetch_count}, 32'h0);
    idle(1); chk("run_addr0", ins_addr, 32'h0); chk("run_vld", {31'b0, fetch_valid}, 32'h1);
    idle(1); chk("run_addr4", ins_addr, 32'h4);
    idle(1); chk("run_addr8", ins_addr, 32'h8);
    idle(1); chk("cnt3", {28'b0, fetch_count}, 32'h3);

    // Backward branch then absolute jump
    idle(1); chk("at_10", ins_addr, 32'h10);
    cyc(1, 0, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0, 0); chk("br_back", ins_addr, 32'h0C);
    cyc(1, 0, 0, 32'h0, 1, 26'h40, 0, 32'h0, 0); chk("jump_100", ins_addr, 32'h100);

    // jr aligned, then misaligned trap that sticks until reset
    do_jr(32'h20); do_jr(32'h84); chk("jr_84", ins_addr, 32'h84);
    do_jr(32'h20);
    do_jr(32'h86);
    chk("mis_addr", ins_addr, 32'h20);
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
    chk("mis_vld", {31'b0, fetch_valid}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h4, 1, 26'h3, 1, 32'h40, 0);
    chk("mis_hold", ins_addr, 32'h20);
    chk("mis_hold_err", {31'b0, misalign_err}, 32'h1);
    do_reset(1);
    chk("mis_clr", {31'b0, misalign_err}, 32'h0);

    // Stall outranks a pending jump, then the jump lands
    idle(3); chk("st_at8", ins_addr, 32'h8);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0, 1, 26'h10, 0, 32'h0, 0);
    chk("st_addr", ins_addr, 32'h8);
    chk("st_cnt", {28'b0, fetch_count}, 32'h2);
    cyc(1, 0, 0, 32'h0, 1, 26'h10, 0, 32'h0, 0); chk("st_rel_jump", ins_addr, 32'h40);

    // halt_req with stall, ignored controls, then reset out of HALT
    do_jr(32'h14);
    cyc(1, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0, 1);
    chk("halt_hlt", {31'b0, halted}, 32'h1);
    chk("halt_addr", ins_addr, 32'h14);
    for (int i = 0; i < 2; i++) cyc(1, 0, 1, 32'h8, 1, 26'h5, 1, 32'h200, 0);
    chk("halt_hold", ins_addr, 32'h14);
    do_reset(1);
    chk("halt_rst_addr", ins_addr, 32'h0);
    chk("halt_rst_hlt", {31'b0, halted}, 32'h0);

    // Wrap around the top of the address space
    idle(1);
    do_jr(32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4, 32'h0);
    idle(1);
    chk("wrap_addr", ins_addr, 32'h0);
    chk("wrap_p4b", pc_plus4, 32'h4);

    // Counter saturation, then reset mid-RUN with controls high
    idle(20);
    chk("cnt_sat", {28'b0, fetch_count}, 32'hF);
    cyc(0, 0, 1, 32'h4, 1, 26'h7, 0, 32'h0, 0);
    chk("rst_run_addr", ins_addr, 32'h0);
    chk("rst_run_vld", {31'b0, fetch_valid}, 32'h0);
    chk("rst_run_cnt", {28'b0, fetch_count}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
